// File: rtl/four_by_two_divider_if.sv
// ---------------------------------------------------------------------------
// four_by_two_divider_if
// Request/result bundle for the 4-bit by 2-bit divider.
//   Start   - request to begin a division (only honoured while idle)
//   N       - 4-bit unsigned dividend, captured with an accepted Start
//   D       - 2-bit unsigned divisor, captured with an accepted Start
//   Q       - 4-bit unsigned quotient
//   R       - 2-bit unsigned remainder
//   Busy    - high while the restoring iterations are running
//   Done    - one-cycle pulse qualifying Q, R and DivZero
//   DivZero - the captured divisor was zero
// master: the requester side; slave: the divider side.
// ---------------------------------------------------------------------------
interface four_by_two_divider_if;
  logic       Start;
  logic [3:0] N;
  logic [1:0] D;
  logic [3:0] Q;
  logic [1:0] R;
  logic       Busy;
  logic       Done;
  logic       DivZero;

  modport master (
    output Start, N, D,
    input  Q, R, Busy, Done, DivZero
  );

  modport slave (
    input  Start, N, D,
    output Q, R, Busy, Done, DivZero
  );
endinterface

// File: rtl/four_by_two_divider.sv
// ---------------------------------------------------------------------------
// four_by_two_divider
// Sequential restoring divider: 4-bit unsigned dividend by 2-bit unsigned
// divisor, one quotient bit per clock, MSB first.
// Ports:
//   CLK  - sole clock, rising edge
//   RST  - synchronous active-high reset
//   bus  - four_by_two_divider_if slave modport (Start/N/D in,
//          Q/R/Busy/Done/DivZero out)
// A non-zero divisor costs four RUN cycles followed by one DONE cycle; a
// zero divisor goes straight to DONE with Q=4'hF, R=0, DivZero=1.
// ---------------------------------------------------------------------------
module four_by_two_divider (
  input  logic                  CLK,
  input  logic                  RST,
  four_by_two_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] nCap_q, nCap_d;
  logic [1:0] dCap_q, dCap_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] rem_q, rem_d;
  logic [3:0] quo_q, quo_d;
  logic [1:0] res_q, res_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       divZero_q, divZero_d;

  // Restoring step datapath: shift the next dividend bit into the running
  // remainder and trial-subtract the divisor. The remainder is always below
  // the divisor, so the 3-bit partial value minus the divisor fits in 2 bits.
  logic [2:0] partial;
  logic [2:0] partialSub;
  logic       fits;
  logic [1:0] remStep;

  always_comb begin
    partial    = {rem_q, nCap_q[cnt_q]};
    partialSub = partial - {1'b0, dCap_q};
    fits       = (partial >= {1'b0, dCap_q});
    remStep    = fits ? partialSub[1:0] : partial[1:0];
  end

  // Next-state and next-output logic. Busy and Done are derived from the
  // next state so that both come straight out of flops.
  always_comb begin
    state_d   = state_q;
    nCap_d    = nCap_q;
    dCap_d    = dCap_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    res_d     = res_q;
    divZero_d = divZero_q;

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          nCap_d    = bus.N;
          dCap_d    = bus.D;
          divZero_d = 1'b0;
          if (bus.D == 2'd0) begin
            state_d   = DONE;
            quo_d     = 4'hF;
            res_d     = 2'd0;
            divZero_d = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = 2'd3;
            rem_d   = 2'd0;
            // Clearing the quotient keeps not-yet-computed bits at zero.
            quo_d   = 4'd0;
            res_d   = 2'd0;
          end
        end
      end

      RUN: begin
        rem_d        = remStep;
        quo_d[cnt_q] = fits;
        if (cnt_q == 2'd0) begin
          res_d   = remStep;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset wins over everything, including a
  // division in flight, so an aborted run never produces a Done pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      nCap_q    <= 4'd0;
      dCap_q    <= 2'd0;
      cnt_q     <= 2'd0;
      rem_q     <= 2'd0;
      quo_q     <= 4'd0;
      res_q     <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      nCap_q    <= nCap_d;
      dCap_q    <= dCap_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      res_q     <= res_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divZero_q <= divZero_d;
    end
  end

  assign bus.Q       = quo_q;
  assign bus.R       = res_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.DivZero = divZero_q;

endmodule

// File: tb/tb_four_by_two_divider.sv
// ---------------------------------------------------------------------------
// tb_four_by_two_divider
// Self-checking bench for four_by_two_divider. Expected results are queued
// when a division is launched and popped when Done is seen; Busy is compared
// every cycle against the windows the bench expects it to be high in.
// ---------------------------------------------------------------------------
module tb_four_by_two_divider;

  typedef struct {
    logic [3:0] n;
    logic [1:0] d;
    logic [3:0] q;
    logic [1:0] r;
    logic       dz;
  } vec_t;

  typedef struct {
    int         doneEdge;
    logic [3:0] q;
    logic [1:0] r;
    logic       dz;
  } exp_t;

  typedef struct {
    int first;
    int last;
  } win_t;

  logic clk;
  logic rst;

  four_by_two_divider_if dif ();

  four_by_two_divider dut (
    .CLK (clk),
    .RST (rst),
    .bus (dif)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  int   edgeCnt     = 0;
  exp_t expQ[$];
  win_t busyWin[$];

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports a miscompare.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)",
               name, actual, required, edgeCnt);
    end
  endtask

  function automatic logic busyExpected(input int e);
    logic b;
    b = 1'b0;
    foreach (busyWin[i])
      if (e >= busyWin[i].first && e <= busyWin[i].last) b = 1'b1;
    return b;
  endfunction

  // Edge counter and output monitor: sample 1 unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    edgeCnt++;
    #1;
    checkOutput("busy", dif.Busy, busyExpected(edgeCnt));
    if (dif.Done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("done_edge", edgeCnt, e.doneEdge);
        checkOutput("quotient", dif.Q, e.q);
        checkOutput("remainder", dif.R, e.r);
        checkOutput("divzero", dif.DivZero, e.dz);
      end
    end
  end

  // Wait (bounded) for a cycle where the DUT is neither running nor done.
  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (!dif.Busy && !dif.Done) ok = 1'b1;
    end
    if (!ok) checkOutput("idle_timeout", 0, 1);
  endtask

  function automatic void expectResult(input int k, input logic [1:0] d,
                                       input logic [3:0] q, input logic [1:0] r,
                                       input logic dz);
    exp_t e;
    win_t w;
    e.doneEdge = (d == 2'd0) ? k : k + 4;
    e.q        = q;
    e.r        = r;
    e.dz       = dz;
    expQ.push_back(e);
    if (d != 2'd0) begin
      w.first = k;
      w.last  = k + 3;
      busyWin.push_back(w);
    end
  endfunction

  // Launch one division with a single-cycle Start pulse.
  task automatic applyStimulus(input logic [3:0] n, input logic [1:0] d,
                               input logic [3:0] q, input logic [1:0] r,
                               input logic dz);
    waitIdle();
    dif.Start = 1'b1;
    dif.N     = n;
    dif.D     = d;
    expectResult(edgeCnt + 1, d, q, r, dz);
    @(posedge clk);
    #1;
    dif.Start = 1'b0;
    dif.N     = 4'($urandom);
    dif.D     = 2'($urandom);
  endtask

  vec_t table_v[$];

  initial begin
    int   k;
    win_t w;

    rst       = 1'b1;
    dif.Start = 1'b0;
    dif.N     = 4'd0;
    dif.D     = 2'd0;

    table_v = '{
      '{4'd13, 2'd3, 4'd4,  2'd1, 1'b0},
      '{4'd15, 2'd1, 4'd15, 2'd0, 1'b0},
      '{4'd2,  2'd3, 4'd0,  2'd2, 1'b0},
      '{4'd9,  2'd2, 4'd4,  2'd1, 1'b0},
      '{4'd9,  2'd0, 4'd15, 2'd0, 1'b1},
      '{4'd0,  2'd1, 4'd0,  2'd0, 1'b0},
      '{4'd15, 2'd3, 4'd5,  2'd0, 1'b0},
      '{4'd7,  2'd2, 4'd3,  2'd1, 1'b0},
      '{4'd15, 2'd2, 4'd7,  2'd1, 1'b0},
      '{4'd1,  2'd3, 4'd0,  2'd1, 1'b0},
      '{4'd0,  2'd0, 4'd15, 2'd0, 1'b1}
    };

    // Reset state, with Start asserted to show reset takes priority.
    repeat (2) @(negedge clk);
    dif.Start = 1'b1;
    @(negedge clk);
    checkOutput("reset_q", dif.Q, 0);
    checkOutput("reset_r", dif.R, 0);
    checkOutput("reset_busy", dif.Busy, 0);
    checkOutput("reset_done", dif.Done, 0);
    checkOutput("reset_divzero", dif.DivZero, 0);
    dif.Start = 1'b0;
    rst       = 1'b0;

    // Table-driven vectors.
    foreach (table_v[i])
      applyStimulus(table_v[i].n, table_v[i].d, table_v[i].q,
                    table_v[i].r, table_v[i].dz);

    // Divide by zero, then a normal division: accept must clear DivZero and
    // the quotient bits that are still to be computed.
    applyStimulus(4'd9, 2'd0, 4'd15, 2'd0, 1'b1);
    waitIdle();
    dif.Start = 1'b1;
    dif.N     = 4'd13;
    dif.D     = 2'd3;
    expectResult(edgeCnt + 1, 2'd3, 4'd4, 2'd1, 1'b0);
    @(posedge clk);
    #1;
    dif.Start = 1'b0;
    checkOutput("accept_q_cleared", dif.Q, 0);
    checkOutput("accept_divzero_cleared", dif.DivZero, 0);

    // Results hold through idle cycles.
    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("hold_q", dif.Q, 4);
    checkOutput("hold_r", dif.R, 1);
    checkOutput("hold_divzero", dif.DivZero, 0);

    // Start held high across a whole division, N changed mid-run: the run
    // uses the captured N, and the next accept lands one idle cycle after Done.
    waitIdle();
    dif.Start = 1'b1;
    dif.N     = 4'd6;
    dif.D     = 2'd2;
    k = edgeCnt + 1;
    expectResult(k, 2'd2, 4'd3, 2'd0, 1'b0);
    expectResult(k + 6, 2'd2, 4'd7, 2'd1, 1'b0);
    @(posedge clk);
    #1;
    dif.N = 4'd15;
    while (edgeCnt < k + 6) begin
      @(posedge clk);
      #1;
    end
    dif.Start = 1'b0;

    // Reset in the second RUN cycle aborts the division with no Done.
    waitIdle();
    dif.Start = 1'b1;
    dif.N     = 4'd12;
    dif.D     = 2'd3;
    k = edgeCnt + 1;
    w.first = k;
    w.last  = k + 1;
    busyWin.push_back(w);
    @(posedge clk);
    #1;
    dif.Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_busy", dif.Busy, 0);
    checkOutput("abort_done", dif.Done, 0);
    checkOutput("abort_q", dif.Q, 0);
    checkOutput("abort_r", dif.R, 0);
    checkOutput("abort_divzero", dif.DivZero, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'd12, 2'd3, 4'd4, 2'd0, 1'b0);

    // All dividend/divisor combinations against the arithmetic reference.
    for (int n = 0; n < 16; n++) begin
      for (int d = 0; d < 4; d++) begin
        if (d == 0)
          applyStimulus(4'(n), 2'(d), 4'hF, 2'd0, 1'b1);
        else
          applyStimulus(4'(n), 2'(d), 4'(n / d), 2'(n % d), 1'b0);
      end
    end

    // Drain outstanding results; anything left over never produced Done.
    for (int i = 0; i < 100 && expQ.size() != 0; i++) @(negedge clk);
    while (expQ.size() != 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput("missing_done", 0, 1);
    end
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
